// File: rtl/sequence_generator_pkg.sv
// Shared definitions for the pattern transmitter: FSM state encodings and the
// active-low 7-segment digit lookup (also used by the detector's display).
package sequence_generator_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Segment order {a,b,c,d,e,f,g}; a 0 lights the segment.
    function automatic logic [6:0] seg_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sequence_generator_if.sv
// Control and serial-output bundle of the pattern transmitter.
// SEQGEN_SELF_CHECK_EN adds the shadow-detector match output.
interface sequence_generator_if #(
    parameter int PATTERN_LEN = 4
);
    logic                   start;
    logic                   stop;
    logic                   repeat_en;
    logic [PATTERN_LEN-1:0] pattern;
    logic                   tx_bit;
    logic                   bit_clk;
    logic                   busy;
    logic                   done;
    logic [6:0]             seg;

`ifdef SEQGEN_SELF_CHECK_EN
    logic                   match;

    modport master (output start, stop, repeat_en, pattern,
                    input  tx_bit, bit_clk, busy, done, seg, match);
    modport slave  (input  start, stop, repeat_en, pattern,
                    output tx_bit, bit_clk, busy, done, seg, match);
`else
    modport master (output start, stop, repeat_en, pattern,
                    input  tx_bit, bit_clk, busy, done, seg);
    modport slave  (input  start, stop, repeat_en, pattern,
                    output tx_bit, bit_clk, busy, done, seg);
`endif

endinterface

// File: rtl/seqgen_tick_div.sv
// Bit-period divider: counts clk cycles per bit and produces the end-of-bit
// tick plus a registered bit clock that rises exactly mid-period.
module seqgen_tick_div #(
    parameter int TICK_DIV = 20000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy_next,
    input  logic clear,
    output logic tick,
    output logic bit_clk
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(TICK_DIV / 2);

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             bit_clk_q, bit_clk_d;

    assign tick    = (tick_cnt_q == LAST);
    assign bit_clk = bit_clk_q;

    // bit_clk is computed from next-cycle values so the flop output equals
    // busy && tick_cnt >= TICK_DIV/2 in the same cycle as the count.
    always_comb begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
        if (clear || !busy_next || tick)
            tick_cnt_d = '0;
        bit_clk_d = busy_next && (tick_cnt_d >= HALF);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            bit_clk_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            bit_clk_q  <= bit_clk_d;
        end
    end

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first with a
// mid-bit sample clock and a 7-segment bit count. SEQGEN_SELF_CHECK_EN adds a shadow detector.
module sequence_generator #(
    parameter int   PATTERN_LEN = 4,
    parameter int   TICK_DIV    = 20000000,
    parameter int   GAP_BITS    = 2,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    sequence_generator_if.slave bus
);
    import sequence_generator_pkg::*;

    localparam int GAP_W = $clog2(GAP_BITS + 2);

    logic [1:0]             state_q, state_d;
    logic [PATTERN_LEN-1:0] shift_q, shift_d;
    logic [PATTERN_LEN-1:0] pat_q, pat_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   done_q, done_d;
    logic                   accept, frame_end, last_bit, last_gap;
    logic                   tick, bit_clk, busy_next, tx_bit;

    assign last_bit  = (int'(bit_cnt_q) == PATTERN_LEN - 1);
    assign last_gap  = (int'(gap_cnt_q) == GAP_BITS - 1);
    assign busy_next = (state_d != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        pat_d     = pat_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    accept    = 1'b1;
                    pat_d     = bus.pattern;
                    shift_d   = bus.pattern;
                    bit_cnt_d = '0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tick) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    shift_d   = shift_q << 1;
                    if (last_bit) begin
                        if (GAP_BITS > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    if (last_gap)
                        frame_end = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Repeats replay the pattern captured at the original start.
        if (frame_end) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            if (bus.repeat_en) begin
                shift_d = pat_q;
                state_d = ST_SEND;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (bus.stop) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        pat_q <= pat_d;
    end

    seqgen_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy_next (busy_next),
        .clear     (accept),
        .tick      (tick),
        .bit_clk   (bit_clk)
    );

    assign tx_bit      = (state_q == ST_SEND) ? shift_q[PATTERN_LEN-1] : IDLE_LEVEL;
    assign bus.tx_bit  = tx_bit;
    assign bus.bit_clk = bit_clk;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.seg     = seg_digit(bit_cnt_q);

`ifdef SEQGEN_SELF_CHECK_EN
    logic [PATTERN_LEN-1:0] hist_q, hist_d, hist_shift;
    logic                   bit_clk_dly_q, bit_clk_rise;

    assign bit_clk_rise = bit_clk && !bit_clk_dly_q;
    assign hist_shift   = (hist_q << 1) | PATTERN_LEN'(tx_bit);

    always_comb begin
        hist_d = hist_q;
        if (bus.stop)
            hist_d = '0;
        else if (bit_clk_rise)
            hist_d = hist_shift;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q        <= '0;
            bit_clk_dly_q <= 1'b0;
        end else begin
            hist_q        <= hist_d;
            bit_clk_dly_q <= bit_clk;
        end
    end

    // Only the frame's final sample may match, so windows straddling the
    // idle gap and the next frame cannot alias the pattern.
    assign bus.match = bit_clk_rise && !bus.stop && (state_q == ST_SEND) &&
                       last_bit && (hist_shift == pat_q);
`endif

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator with TICK_DIV=4, GAP_BITS=2, PATTERN_LEN=4.
// Define SEQGEN_SELF_CHECK_EN to also cover the shadow-detector match output.
module tb_sequence_generator;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    sequence_generator_if #(.PATTERN_LEN(4)) bus ();

    sequence_generator #(
        .PATTERN_LEN (4),
        .TICK_DIV    (4),
        .GAP_BITS    (2),
        .IDLE_LEVEL  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_exp(input int d);
        case (d)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        check_eq({tag, "_tx"}, bus.tx_bit, 1'b1);
        check_eq({tag, "_bitclk"}, bus.bit_clk, 1'b0);
        check_eq({tag, "_seg"}, bus.seg, 7'b0000001);
        check_eq({tag, "_done"}, bus.done, 1'b0);
`ifdef SEQGEN_SELF_CHECK_EN
        check_eq({tag, "_match"}, bus.match, 1'b0);
`endif
    endtask

    // k counts cycles observed after the accepting (or reloading) edge.
    task automatic expect_frame(input logic [3:0] pat, input logic first_done, input bit poke);
        for (int k = 0; k < 24; k++) begin
            check_eq($sformatf("tx[%0d]", k), bus.tx_bit, (k < 16) ? pat[3 - k / 4] : 1'b1);
            check_eq($sformatf("busy[%0d]", k), bus.busy, 1'b1);
            check_eq($sformatf("bitclk[%0d]", k), bus.bit_clk, ((k % 4) >= 2) ? 1'b1 : 1'b0);
            check_eq($sformatf("seg[%0d]", k), bus.seg, seg_exp((k < 16) ? k / 4 : 4));
            check_eq($sformatf("done[%0d]", k), bus.done, (k == 0) ? first_done : 1'b0);
`ifdef SEQGEN_SELF_CHECK_EN
            check_eq($sformatf("match[%0d]", k), bus.match, (k == 14) ? 1'b1 : 1'b0);
`endif
            if (poke && k == 5) begin
                bus.start   = 1'b1;
                bus.pattern = 4'b1111;
            end
            if (poke && k == 6)
                bus.start = 1'b0;
            step();
        end
    endtask

    task automatic end_frame(input logic [3:0] pat, input logic rep);
        check_eq("end_done", bus.done, 1'b1);
        check_eq("end_busy", bus.busy, rep);
        check_eq("end_seg", bus.seg, 7'b0000001);
        check_eq("end_tx", bus.tx_bit, rep ? pat[3] : 1'b1);
        check_eq("end_bitclk", bus.bit_clk, 1'b0);
        if (!rep) begin
            step();
            check_idle("post_end");
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.repeat_en = 1'b0;
        bus.pattern   = 4'b0000;
        step();
        step();
        check_idle("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_idle("idle");
        end

        // Single frame, no repeat.
        bus.pattern = 4'b0110;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        expect_frame(4'b0110, 1'b0, 1'b0);
        end_frame(4'b0110, 1'b0);

        // Repeating frame; the pattern port changes after start and a start
        // pulse lands mid-frame, neither of which may disturb the output.
        bus.repeat_en = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start   = 1'b0;
        bus.pattern = 4'b1111;
        expect_frame(4'b0110, 1'b0, 1'b0);
        end_frame(4'b0110, 1'b1);
        bus.repeat_en = 1'b0;
        expect_frame(4'b0110, 1'b1, 1'b1);
        end_frame(4'b0110, 1'b0);

        // Abort after two bits, then restart one cycle later.
        bus.pattern = 4'b0110;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check_eq("pre_stop_seg", bus.seg, 7'b0010010);
        check_eq("pre_stop_tx", bus.tx_bit, 1'b1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check_idle("stop");
        step();
        check_idle("stop_hold");
        bus.pattern = 4'b1010;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        check_eq("restart_busy", bus.busy, 1'b1);
        check_eq("restart_tx", bus.tx_bit, 1'b1);
        check_eq("restart_seg", bus.seg, 7'b0000001);
        for (int i = 0; i < 4; i++) step();
        check_eq("restart_tx1", bus.tx_bit, 1'b0);
        check_eq("restart_seg1", bus.seg, 7'b1001111);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check_idle("stop2");

        // Simultaneous start and stop in IDLE: stop wins.
        bus.pattern = 4'b0110;
        bus.start   = 1'b1;
        bus.stop    = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_idle("start_stop");
        step();
        check_idle("start_stop_hold");

        // Reset asserted mid-frame.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_eq("midrst_busy_before", bus.busy, 1'b1);
        rst_n = 1'b0;
        step();
        check_idle("midrst");
        rst_n = 1'b1;
        step();
        check_idle("midrst_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
